// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, bubble encoding, immediate formats
// and the ID/EX pipeline payload.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              memread;
        logic              regwrite;
        logic              illegal;
    } id_ex_t;

    // Sign-extended immediate for a given encoding format.
    function automatic logic [XLEN-1:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] inst);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous write port,
// write-through bypass, x0 hardwired to zero.
module regfile
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1_c,
    output logic [XLEN-1:0]   o_rdata2_c,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle write to the addressed register wins over the stored value.
    always_comb begin
        o_rdata1_c = r_mem[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1_c = '0;
        end else if (w_wr_en && (i_waddr == i_raddr1)) begin
            o_rdata1_c = i_wdata;
        end
    end

    always_comb begin
        o_rdata2_c = r_mem[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2_c = '0;
        end else if (w_wr_en && (i_waddr == i_raddr2)) begin
            o_rdata2_c = i_wdata;
        end
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: field and immediate decode, register read, load-use stall
// detection and the ID/EX pipeline register.
module decode
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic [XLEN-1:0] IF_ID_pc,
    input  logic [31:0]     IF_ID_inst,
    input  logic            branch_taken,
    input  logic            WB_we,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_data,
    output logic            Load_bubble,
    output logic            ID_EX_valid,
    output logic [XLEN-1:0] ID_EX_pc,
    output logic [6:0]      ID_EX_opcode,
    output logic [2:0]      ID_EX_funct3,
    output logic [6:0]      ID_EX_funct7,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic            ID_EX_memread,
    output logic            ID_EX_regwrite,
    output logic            ID_EX_illegal
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic              w_valid;
    logic              w_supported;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_writes_rd;
    logic              w_is_load;
    imm_fmt_e          w_imm_fmt;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;
    logic [XLEN-1:0]   w_imm;
    logic              w_hazard;
    logic              w_bubble;
    id_ex_t            w_id_ex_d;
    id_ex_t            r_id_ex;

    assign w_opcode = IF_ID_inst[6:0];
    assign w_rd     = IF_ID_inst[11:7];
    assign w_funct3 = IF_ID_inst[14:12];
    assign w_rs1    = IF_ID_inst[19:15];
    assign w_rs2    = IF_ID_inst[24:20];
    assign w_funct7 = IF_ID_inst[31:25];
    assign w_valid  = (IF_ID_inst != NOP_INST);

    // Opcode class: operand usage, destination write and immediate format.
    always_comb begin
        w_supported = 1'b1;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        w_imm_fmt   = IMM_NONE;
        case (w_opcode)
            LUI, AUIPC: begin
                w_writes_rd = 1'b1;
                w_imm_fmt   = IMM_U;
            end
            JAL: begin
                w_writes_rd = 1'b1;
                w_imm_fmt   = IMM_J;
            end
            JALR, MCC: begin
                w_use_rs1   = 1'b1;
                w_writes_rd = 1'b1;
                w_imm_fmt   = IMM_I;
            end
            BCC: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm_fmt = IMM_B;
            end
            LCC: begin
                w_use_rs1   = 1'b1;
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
                w_imm_fmt   = IMM_I;
            end
            SCC: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm_fmt = IMM_S;
            end
            RCC: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_writes_rd = 1'b1;
            end
            SYS: begin
                w_writes_rd = 1'b1;
                w_imm_fmt   = IMM_I;
            end
            default: begin
                w_supported = 1'b0;
            end
        endcase
    end

    assign w_imm = gen_imm(w_imm_fmt, IF_ID_inst);

    regfile #(
        .XLEN(XLEN)
    ) u_regfile (
        .clk        (CLK),
        .rst_n      (RES),
        .i_raddr1   (w_rs1),
        .i_raddr2   (w_rs2),
        .o_rdata1_c (w_rs1_data),
        .o_rdata2_c (w_rs2_data),
        .i_we       (WB_we),
        .i_waddr    (WB_rd),
        .i_wdata    (WB_data)
    );

    // A load in ID/EX whose destination feeds an operand actually used here must stall one cycle.
    assign w_hazard = r_id_ex.valid && r_id_ex.memread && (r_id_ex.rd != '0) && w_valid &&
                      ((w_use_rs1 && (w_rs1 == r_id_ex.rd)) ||
                       (w_use_rs2 && (w_rs2 == r_id_ex.rd)));

    assign Load_bubble = w_hazard && !branch_taken;
    assign w_bubble    = branch_taken || w_hazard || !w_valid;

    always_comb begin
        w_id_ex_d = '0;
        if (!w_bubble) begin
            w_id_ex_d.valid    = 1'b1;
            w_id_ex_d.pc       = IF_ID_pc;
            w_id_ex_d.opcode   = w_opcode;
            w_id_ex_d.funct3   = w_funct3;
            w_id_ex_d.funct7   = w_funct7;
            w_id_ex_d.rs1      = w_rs1;
            w_id_ex_d.rs2      = w_rs2;
            w_id_ex_d.rd       = w_rd;
            w_id_ex_d.rs1_data = w_rs1_data;
            w_id_ex_d.rs2_data = w_rs2_data;
            w_id_ex_d.imm      = w_imm;
            w_id_ex_d.memread  = w_is_load;
            w_id_ex_d.regwrite = w_writes_rd && (w_rd != '0);
            w_id_ex_d.illegal  = !w_supported;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_id_ex_d;
        end
    end

    assign ID_EX_valid    = r_id_ex.valid;
    assign ID_EX_pc       = r_id_ex.pc;
    assign ID_EX_opcode   = r_id_ex.opcode;
    assign ID_EX_funct3   = r_id_ex.funct3;
    assign ID_EX_funct7   = r_id_ex.funct7;
    assign ID_EX_rs1      = r_id_ex.rs1;
    assign ID_EX_rs2      = r_id_ex.rs2;
    assign ID_EX_rd       = r_id_ex.rd;
    assign ID_EX_rs1_data = r_id_ex.rs1_data;
    assign ID_EX_rs2_data = r_id_ex.rs2_data;
    assign ID_EX_imm      = r_id_ex.imm;
    assign ID_EX_memread  = r_id_ex.memread;
    assign ID_EX_regwrite = r_id_ex.regwrite;
    assign ID_EX_illegal  = r_id_ex.illegal;

endmodule
